ad9866_cfg_ctrl: RTL and testbench
==================================

AD9866_CFG_CTRL -- requirements
Module: ad9866_cfg_ctrl

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (minimum 2).
REQ-002 SHALL provide parameter RST_CYCLES, default 1024, meaning clk cycles ad9866_rst_n is held low.
REQ-003 SHALL provide parameter WAKE_CYCLES, default 4096, meaning clk cycles between rst_n release and the first frame.
REQ-004 SHALL provide parameter GAP_CYCLES, default 2, meaning minimum sen_n-high clk cycles between frames.
REQ-005 SHALL provide the port clk, input, 1 bit, the single clock.
REQ-006 SHALL provide the port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL provide the port cmd_valid, input, 1 bit, host frame request.
REQ-008 SHALL provide the port cmd_ready, output, 1 bit, controller accepts cmd_data this cycle.
REQ-009 SHALL provide the port cmd_data, input, 16 bits: [15] read=1/write=0, [14:8] register address, [7:0] write data.
REQ-010 SHALL provide the port rd_data, output, 8 bits, last read result.
REQ-011 SHALL provide the port rd_valid, output, 1 bit, one-cycle pulse when rd_data updates.
REQ-012 SHALL provide the port init_done, output, 1 bit, init table complete (sticky until rst).
REQ-013 SHALL provide the port busy, output, 1 bit, frame or gap in progress.
REQ-014 SHALL provide the ports ad9866_sclk, ad9866_sdio, ad9866_sen_n and ad9866_rst_n, outputs, 1 bit each, AD9866 SPI and reset pins.
REQ-015 SHALL provide the port ad9866_sdo, input, 1 bit, AD9866 serial readback.

Function
REQ-016 SHALL sequence states RST_HOLD -> WAKE -> INIT -> SHIFT -> GAP -> (INIT | IDLE); IDLE -> SHIFT on accepted host command.
REQ-017 RST_HOLD: ad9866_rst_n=0 for RST_CYCLES cycles, then 1; WAKE counts WAKE_CYCLES, then goes to INIT.
REQ-018 INIT SHALL issue init-table entries 0..INIT_LEN-1 in order, one frame each, without host interleave.
REQ-019 After the last init frame's GAP, init_done SHALL go 1 and the state SHALL go to IDLE.
REQ-020 cmd_ready SHALL be 1 only in IDLE with init_done=1; handshake = cmd_valid & cmd_ready; cmd_ready SHALL be 0 the following cycle.
REQ-021 Host requests during init or a frame SHALL be held off (no drop, no queue); cmd_data is sampled only on handshake.
REQ-022 Frame: 16 bits MSB first; sen_n low and sdio=bit15 in the first SHIFT cycle; sclk idle low.
REQ-023 Each bit: sclk low CLK_DIV cycles then high CLK_DIV cycles; sdio changes only at the start of a low phase.
REQ-024 After the 16th high phase: sclk low, sen_n high CLK_DIV cycles later; frame length = 33*CLK_DIV cycles.
REQ-025 GAP SHALL hold sen_n=1, sclk=0 for GAP_CYCLES cycles; busy=1 throughout SHIFT and GAP.
REQ-026 Read frame: sdo SHALL be sampled on the clk cycle each of sclk edges 9..16 rises, MSB first, and sdio SHALL be 0 during bits 7..0.
REQ-027 On read-frame end, rd_data SHALL be updated and rd_valid SHALL pulse exactly 1 cycle in the sen_n-rising cycle; writes SHALL leave rd_data unchanged.
REQ-028 cmd_valid deasserted in the handshake cycle SHALL be irrelevant; the accepted frame always completes.

Reset
REQ-029 rst, sampled at any state including mid-frame, SHALL in the next cycle force RST_HOLD, sen_n=1, sclk=0, sdio=0, rst_n=0, cmd_ready=0, rd_valid=0, busy=0, init_done=0, rd_data=0, all counters=0.
REQ-030 The init sequence SHALL restart from entry 0 after every reset.

Structure
REQ-031 Package ad9866_pkg SHALL hold the state enum, the cmd field positions (RW bit, ADDR, DATA), INIT_LEN and the init table constant.
REQ-032 Sub-module ad9866_spi_shifter SHALL implement REQ-022..REQ-026 (start/done handshake, 16-bit in, 8-bit out); the parent holds the FSM and the counters.

Verification
REQ-033 rst 1 cycle -> rst_n low exactly 1024 cycles; first sen_n fall 4096 cycles after rst_n rise.
REQ-034 Init with INIT_LEN=8, CLK_DIV=4 -> 8 frames of 132 cycles, gaps >= 2, decoded words match the table, then init_done=1.
REQ-035 Host write 0x0A5C after init -> sdio bitstream 0000_1010_0101_1100 sampled on sclk rises; rd_valid stays 0.
REQ-036 Host read 0x8500 with sdo model returning 0xC3 -> rd_data=0xC3, single rd_valid pulse at sen_n rise.
REQ-037 cmd_valid held high from time 0 -> first handshake only after init_done; back-to-back frames separated by exactly GAP_CYCLES.
REQ-038 rst asserted mid-bit 7 of a frame -> next cycle sen_n=1, sclk=0, rst_n=0; full init repeats from entry 0.

Source files
------------

// File: rtl/ad9866_pkg.sv
// Shared types and constants for the AD9866 configuration controller:
// FSM states, host command field layout and the power-up register table.
package ad9866_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_WAKE,
    ST_INIT,
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  localparam int CMD_W        = 16;
  localparam int CMD_RW_BIT   = 15;
  localparam int CMD_ADDR_MSB = 14;
  localparam int CMD_ADDR_LSB = 8;
  localparam int CMD_DATA_MSB = 7;
  localparam int CMD_DATA_LSB = 0;

  localparam int INIT_LEN   = 8;
  localparam int INIT_IDX_W = $clog2(INIT_LEN);

  // Power-up writes, issued from entry 0 upwards: {rw, addr[6:0], data[7:0]}
  localparam logic [0:INIT_LEN-1][CMD_W-1:0] INIT_TABLE = {
    16'h0154, 16'h0204, 16'h0300, 16'h0441,
    16'h0520, 16'h0700, 16'h0881, 16'h0E80
  };

  // Word actually shifted out: a read drives zeros in place of the data byte.
  function automatic logic [CMD_W-1:0] frame_word(input logic [CMD_W-1:0] cmd);
    logic is_rd;
    is_rd = cmd[CMD_RW_BIT];
    return {cmd[CMD_RW_BIT], cmd[CMD_ADDR_MSB:CMD_ADDR_LSB],
            is_rd ? 8'h00 : cmd[CMD_DATA_MSB:CMD_DATA_LSB]};
  endfunction

endpackage

// File: rtl/ad9866_spi_shifter.sv
// 16-bit MSB-first SPI frame engine for the AD9866: drives sclk/sdio/sen_n,
// captures the read byte from sdo and reports the last cycle of each frame.
module ad9866_spi_shifter
  import ad9866_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CMD_W-1:0] word,
  input  logic             sdo,
  output logic             done,
  output logic             sclk,
  output logic             sdio,
  output logic             sen_n,
  output logic [7:0]       rd_word,
  output logic             rd_strobe
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic             active;
  logic             is_rd;
  logic [5:0]       half_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [CMD_W-1:0] shreg;
  logic [7:0]       sample_sr;
  logic             div_last;
  logic             sample_en;

  assign div_last  = (div_cnt == DIV_W'(CLK_DIV - 1));
  // Half-phases 0..31 are the 16 bits (even = low, odd = high); 32 is the trailing low.
  assign done      = active && (half_cnt == 6'd32) && div_last;
  // First clk cycle of sclk rises 9..16 carries the read byte.
  assign sample_en = active && sclk && (div_cnt == '0) && (half_cnt >= 6'd17);

  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= 1'b0;
      is_rd     <= 1'b0;
      half_cnt  <= '0;
      div_cnt   <= '0;
      shreg     <= '0;
      sample_sr <= '0;
      sclk      <= 1'b0;
      sdio      <= 1'b0;
      sen_n     <= 1'b1;
      rd_word   <= '0;
      rd_strobe <= 1'b0;
    end else begin
      rd_strobe <= 1'b0;
      if (start) begin
        active   <= 1'b1;
        is_rd    <= word[CMD_RW_BIT];
        half_cnt <= '0;
        div_cnt  <= '0;
        shreg    <= frame_word(word);
        sen_n    <= 1'b0;
        sclk     <= 1'b0;
        sdio     <= word[CMD_W-1];
      end else if (active) begin
        if (sample_en) begin
          sample_sr <= {sample_sr[6:0], sdo};
        end
        if (div_last) begin
          div_cnt <= '0;
          if (half_cnt == 6'd32) begin
            active <= 1'b0;
            sen_n  <= 1'b1;
            sdio   <= 1'b0;
            if (is_rd) begin
              rd_word   <= sample_sr;
              rd_strobe <= 1'b1;
            end
          end else begin
            half_cnt <= half_cnt + 6'd1;
            if (!half_cnt[0]) begin
              sclk <= 1'b1;
            end else begin
              sclk  <= 1'b0;
              sdio  <= shreg[CMD_W-2];
              shreg <= {shreg[CMD_W-2:0], 1'b0};
            end
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ad9866_cfg_ctrl.sv
// AD9866 configuration controller: resets the chip, plays the init table over
// SPI, then serves host read/write frames one at a time.
module ad9866_cfg_ctrl
  import ad9866_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int RST_CYCLES  = 1024,
  parameter int WAKE_CYCLES = 4096,
  parameter int GAP_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CMD_W-1:0] cmd_data,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             init_done,
  output logic             busy,
  output logic             ad9866_sclk,
  output logic             ad9866_sdio,
  output logic             ad9866_sen_n,
  output logic             ad9866_rst_n,
  input  logic             ad9866_sdo
);

  localparam int CNT_MAX = (RST_CYCLES > WAKE_CYCLES) ?
                           ((RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES) :
                           ((WAKE_CYCLES > GAP_CYCLES) ? WAKE_CYCLES : GAP_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [INIT_IDX_W-1:0] init_idx, idx_next;
  logic                  done_next;
  logic                  rst_n_q;
  logic                  start;
  logic [CMD_W-1:0]      start_word;
  logic                  frame_done;

  assign cmd_ready    = (state == ST_IDLE) && init_done;
  assign busy         = (state == ST_SHIFT) || (state == ST_GAP);
  assign ad9866_rst_n = rst_n_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RST_HOLD;
      cnt       <= '0;
      init_idx  <= '0;
      init_done <= 1'b0;
      rst_n_q   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      init_idx  <= idx_next;
      init_done <= done_next;
      rst_n_q   <= (state_next != ST_RST_HOLD);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = init_idx;
    done_next  = init_done;
    start      = 1'b0;
    start_word = INIT_TABLE[init_idx];
    unique case (state)
      ST_RST_HOLD: begin
        if (cnt == CNT_W'(RST_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = ST_WAKE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      // The INIT issue cycle is the last cycle of the wake interval.
      ST_WAKE: begin
        if (cnt == CNT_W'(WAKE_CYCLES - 2)) begin
          cnt_next   = '0;
          state_next = ST_INIT;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_INIT: begin
        start      = 1'b1;
        state_next = ST_SHIFT;
      end
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          start      = 1'b1;
          start_word = cmd_data;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (frame_done) begin
          cnt_next   = '0;
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_next = '0;
          if (init_done) begin
            state_next = ST_IDLE;
          end else if (init_idx == INIT_IDX_W'(INIT_LEN - 1)) begin
            done_next  = 1'b1;
            idx_next   = '0;
            state_next = ST_IDLE;
          end else begin
            idx_next   = init_idx + 1'b1;
            state_next = ST_INIT;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = ST_RST_HOLD;
    endcase
  end

  ad9866_spi_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .word     (start_word),
    .sdo      (ad9866_sdo),
    .done     (frame_done),
    .sclk     (ad9866_sclk),
    .sdio     (ad9866_sdio),
    .sen_n    (ad9866_sen_n),
    .rd_word  (rd_data),
    .rd_strobe(rd_valid)
  );

endmodule

// File: tb/tb_ad9866_cfg_ctrl.sv
// Directed bench for ad9866_cfg_ctrl: reset timing, init table, host write/read,
// hold-off, back-to-back spacing and mid-frame reset.
module tb_ad9866_cfg_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        init_done;
  logic        busy;
  logic        ad9866_sclk;
  logic        ad9866_sdio;
  logic        ad9866_sen_n;
  logic        ad9866_rst_n;
  logic        ad9866_sdo;

  int checks = 0;
  int errors = 0;

  localparam int FRAME_LEN = 132;  // 33 * CLK_DIV(4)
  localparam int GAP       = 2;

  logic [15:0] exp_init [8] = '{16'h0154, 16'h0204, 16'h0300, 16'h0441,
                                16'h0520, 16'h0700, 16'h0881, 16'h0E80};

  // Bus monitor / sdo model state
  logic [15:0] words[$];
  int          lens[$];
  int          nbits[$];
  int          gaps[$];
  int          gap_busy[$];
  int          cyc = 0;
  int          fall_cyc = 0;
  int          rise_cyc = 0;
  int          rises = 0;
  int          busy_hi = 0;
  int          rdv_count = 0;
  int          bad_hs = 0;
  logic        rdv_at_rise = 1'b0;
  logic [15:0] dec = '0;
  logic [7:0]  sdo_reply = 8'h00;
  logic        p_sen = 1'b1;
  logic        p_sclk = 1'b0;

  ad9866_cfg_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .init_done   (init_done),
    .busy        (busy),
    .ad9866_sclk (ad9866_sclk),
    .ad9866_sdio (ad9866_sdio),
    .ad9866_sen_n(ad9866_sen_n),
    .ad9866_rst_n(ad9866_rst_n),
    .ad9866_sdo  (ad9866_sdo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Decode frames on sclk rises; the chip model drives read bits after each sclk fall.
  initial begin
    ad9866_sdo = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (ad9866_sclk === 1'b1 && p_sclk === 1'b0 && ad9866_sen_n === 1'b0) begin
        dec = {dec[14:0], ad9866_sdio};
        rises++;
      end
      if (ad9866_sclk === 1'b0 && p_sclk === 1'b1 && ad9866_sen_n === 1'b0)
        ad9866_sdo = (rises >= 8 && rises <= 15) ? sdo_reply[15 - rises] : 1'b0;
      if (p_sen === 1'b1 && ad9866_sen_n === 1'b0) begin
        gaps.push_back(cyc - rise_cyc);
        gap_busy.push_back(busy_hi);
        fall_cyc = cyc;
        dec = '0;
        rises = 0;
      end
      if (p_sen === 1'b0 && ad9866_sen_n === 1'b1) begin
        words.push_back(dec);
        lens.push_back(cyc - fall_cyc);
        nbits.push_back(rises);
        rise_cyc = cyc;
        busy_hi = 0;
        rdv_at_rise = rd_valid;
        ad9866_sdo = 1'b0;
      end
      if (ad9866_sen_n === 1'b1 && busy === 1'b1) busy_hi++;
      if (rd_valid === 1'b1) rdv_count++;
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1 && init_done !== 1'b1) bad_hs++;
      p_sen  = ad9866_sen_n;
      p_sclk = ad9866_sclk;
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_data = 16'h0A5C;
    @(negedge clk);
    checks++; if (ad9866_sen_n !== 1'b1) begin errors++; $display("FAIL reset_sen_n got %b want 1", ad9866_sen_n); end
    checks++; if (ad9866_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", ad9866_sclk); end
    checks++; if (ad9866_sdio !== 1'b0) begin errors++; $display("FAIL reset_sdio got %b want 0", ad9866_sdio); end
    checks++; if (ad9866_rst_n !== 1'b0) begin errors++; $display("FAIL reset_rst_n got %b want 0", ad9866_rst_n); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b want 0", cmd_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", init_done); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    rst = 1'b0;
  endtask

  task automatic test_rst_timing;
    int n;
    n = 0;
    while (ad9866_rst_n === 1'b0 && n < 3000) begin n++; @(negedge clk); end
    checks++; if (n !== 1024) begin errors++; $display("FAIL rst_n_low_cycles got %0d want 1024", n); end
    n = 0;
    while (ad9866_sen_n === 1'b1 && n < 6000) begin n++; @(negedge clk); end
    checks++; if (n !== 4096) begin errors++; $display("FAIL wake_to_first_frame got %0d want 4096", n); end
  endtask

  task automatic test_init;
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 3000) begin n++; @(negedge clk); end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_timeout got %b want 1", init_done); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL init_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (bad_hs !== 0) begin errors++; $display("FAIL early_handshake got %0d want 0", bad_hs); end
    checks++; if (words.size() !== 8) begin errors++; $display("FAIL init_frame_count got %0d want 8", words.size()); end
    for (int i = 0; i < 8 && i < words.size(); i++) begin
      checks++; if (words[i] !== exp_init[i]) begin errors++; $display("FAIL init_word%0d got %h want %h", i, words[i], exp_init[i]); end
      checks++; if (lens[i] !== FRAME_LEN || nbits[i] !== 16) begin errors++; $display("FAIL init_len%0d got %0d/%0d want %0d/16", i, lens[i], nbits[i], FRAME_LEN); end
      if (i > 0) begin
        checks++; if (gaps[i] < GAP) begin errors++; $display("FAIL init_gap%0d got %0d want >= %0d", i, gaps[i], GAP); end
      end
    end
    checks++; if (rdv_count !== 0) begin errors++; $display("FAIL init_rd_valid got %0d want 0", rdv_count); end
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL post_hs ready/busy got %b/%b want 0/1", cmd_ready, busy); end
    cmd_data = 16'h8500;
    sdo_reply = 8'hC3;
  endtask

  task automatic test_write;
    int n;
    n = 0;
    while (words.size() < 9 && n < 400) begin n++; @(negedge clk); end
    checks++; if (words.size() < 9) begin errors++; $display("FAIL write_timeout got %0d want 9", words.size()); end
    else begin
      checks++; if (words[8] !== 16'h0A5C) begin errors++; $display("FAIL write_word got %h want 0a5c", words[8]); end
      checks++; if (lens[8] !== FRAME_LEN) begin errors++; $display("FAIL write_len got %0d want %0d", lens[8], FRAME_LEN); end
    end
    checks++; if (rdv_count !== 0 || rd_data !== 8'h00) begin errors++; $display("FAIL write_rd got %0d/%h want 0/00", rdv_count, rd_data); end
  endtask

  task automatic test_back_to_back;
    int n;
    n = 0;
    while (!(cmd_valid === 1'b1 && cmd_ready === 1'b1) && n < 400) begin n++; @(negedge clk); end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data = 16'hFFFF;
    n = 0;
    while (words.size() < 10 && n < 400) begin n++; @(negedge clk); end
    repeat (2) @(negedge clk);
    checks++; if (words.size() < 10) begin errors++; $display("FAIL b2b_timeout got %0d want 10", words.size()); end
    else begin
      checks++; if (gap_busy[9] !== GAP) begin errors++; $display("FAIL b2b_gap_state got %0d want %0d", gap_busy[9], GAP); end
      checks++; if (gaps[9] !== GAP + 1) begin errors++; $display("FAIL b2b_sen_high got %0d want %0d", gaps[9], GAP + 1); end
    end
  endtask

  task automatic test_read;
    int n;
    if (words.size() >= 10) begin
      checks++; if (words[9] !== 16'h8500) begin errors++; $display("FAIL read_word got %h want 8500", words[9]); end
    end
    checks++; if (rd_data !== 8'hC3) begin errors++; $display("FAIL read_data got %h want c3", rd_data); end
    checks++; if (rdv_count !== 1) begin errors++; $display("FAIL read_pulses got %0d want 1", rdv_count); end
    checks++; if (rdv_at_rise !== 1'b1) begin errors++; $display("FAIL read_pulse_at_rise got %b want 1", rdv_at_rise); end
    // Read with a nonzero data byte: sdio must still be zero over bits 7..0.
    cmd_data = 16'h85A5;
    sdo_reply = 8'h3C;
    cmd_valid = 1'b1;
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_ready/busy got %b/%b want 1/0", cmd_ready, busy); end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (words.size() < 11 && n < 400) begin n++; @(negedge clk); end
    repeat (2) @(negedge clk);
    checks++; if (words.size() < 11 || words[10] !== 16'h8500) begin errors++; $display("FAIL read_mask_word got %h want 8500", (words.size() < 11) ? 16'h0 : words[10]); end
    checks++; if (rd_data !== 8'h3C || rdv_count !== 2) begin errors++; $display("FAIL read2 got %h/%0d want 3c/2", rd_data, rdv_count); end
    cmd_data = 16'h1234;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (words.size() < 12 && n < 400) begin n++; @(negedge clk); end
    repeat (2) @(negedge clk);
    checks++; if (words.size() < 12 || words[11] !== 16'h1234) begin errors++; $display("FAIL write2_word got %h want 1234", (words.size() < 12) ? 16'h0 : words[11]); end
    checks++; if (rd_data !== 8'h3C || rdv_count !== 2) begin errors++; $display("FAIL write_keeps_rd got %h/%0d want 3c/2", rd_data, rdv_count); end
  endtask

  task automatic test_mid_reset;
    int n;
    cmd_data = 16'h7FFF;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (rises < 7 && n < 400) begin n++; @(negedge clk); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ad9866_sen_n !== 1'b1 || ad9866_sclk !== 1'b0 || ad9866_sdio !== 1'b0) begin errors++; $display("FAIL midrst_spi got sen_n=%b sclk=%b sdio=%b want 1 0 0", ad9866_sen_n, ad9866_sclk, ad9866_sdio); end
    checks++; if (ad9866_rst_n !== 1'b0) begin errors++; $display("FAIL midrst_rst_n got %b want 0", ad9866_rst_n); end
    checks++; if (busy !== 1'b0 || init_done !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got busy=%b done=%b ready=%b want 0 0 0", busy, init_done, cmd_ready); end
    checks++; if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_rd got %h/%b want 00/0", rd_data, rd_valid); end
    rst = 1'b0;
    @(negedge clk);
    words.delete(); lens.delete(); nbits.delete(); gaps.delete(); gap_busy.delete();
    rdv_count = 0;
    n = 0;
    while (init_done !== 1'b1 && n < 8000) begin n++; @(negedge clk); end
    checks++; if (init_done !== 1'b1 || words.size() !== 8) begin errors++; $display("FAIL reinit got done=%b frames=%0d want 1/8", init_done, words.size()); end
    for (int i = 0; i < 8 && i < words.size(); i++) begin
      checks++; if (words[i] !== exp_init[i] || lens[i] !== FRAME_LEN) begin errors++; $display("FAIL reinit_word%0d got %h/%0d want %h/%0d", i, words[i], lens[i], exp_init[i], FRAME_LEN); end
    end
    checks++; if (rdv_count !== 0) begin errors++; $display("FAIL reinit_rd_valid got %0d want 0", rdv_count); end
  endtask

  initial begin
    test_reset();
    test_rst_timing();
    test_init();
    test_write();
    test_back_to_back();
    test_read();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
